ball_draw_sequencer: RTL and testbench
======================================

# ball_draw_sequencer

Per-frame controller that refreshes the 320x240 RGB frame buffer after each ball move. It erases the previous ball square with the background colour, then paints the new square with the ball colour. Writes go one pixel at a time over a valid/ready write port into the single-port buffer arbiter, so the VGA read path keeps priority. It sits between the game-logic block (position, size, colours) and the frame-buffer write arbiter.

## Interface
- H_RES, 320, frame-buffer width in pixels
- V_RES, 240, frame-buffer height in pixels
- ADDR_W, 17, linear pixel address width (H_RES*V_RES = 76800)
- CLOCK_50  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- frame_tick  input  1  one-cycle start pulse, once per frame
- ball_x  input  11  new ball left column, buffer coordinates
- ball_y  input  11  new ball top row, buffer coordinates
- size  input  7  ball extent; square covers size+1 pixels per side, inclusive
- ball_rgb  input  24  ball colour {r,g,b}, 8 bits each
- bg_rgb  input  24  background colour {r,g,b}
- wr_ready  input  1  arbiter accepts the current write this cycle
- wr_valid  output  1  write request
- wr_addr  output  ADDR_W  linear address, row*H_RES+col
- wr_rgb  output  24  pixel data
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when the sequence completes
- overrun  output  1  sticky flag: frame_tick arrived while busy

## Operation
- States: IDLE, ERASE, DRAW, FINISH.
- IDLE:
  - On frame_tick, latch ball_x, ball_y, size, ball_rgb and bg_rgb into the "new" registers.
  - Go to ERASE if prev_valid is set, otherwise go to DRAW.
- ERASE: scan the previous square (prev_x, prev_y, prev_size) row-major, top-left to bottom-right. Write bg colour to every pixel.
- DRAW: scan the new square the same way and write the latched ball colour.
- FINISH:
  - Copy the new registers into prev_* and set prev_valid.
  - Pulse done and return to IDLE.
- Scan order: col increments first; at col = x0+size, col returns to x0 and row increments. The last pixel is (x0+size, y0+size).
- Clipping:
  - A pixel with col >= H_RES or row >= V_RES is skipped. wr_valid stays low for that cycle and the scan advances one pixel.
  - Coordinate arithmetic is 12 bits wide, so x0+size never wraps.
- Address: row*H_RES + col, computed as (row<<8)+(row<<6)+col when H_RES=320. The result is truncated to ADDR_W.
- Handshake:
  - A transfer occurs on a rising edge where wr_valid && wr_ready.
  - While wr_valid is high and wr_ready is low, wr_addr and wr_rgb hold stable.
  - The scan advances only on a transfer or on a skipped pixel.
- frame_tick while busy (ERASE, DRAW or FINISH):
  - The tick is ignored and overrun is set.
  - The running sequence is unaffected and the inputs are not re-latched.
- Mid-sequence input changes have no effect, because all inputs are latched at start.
- overrun is cleared only by reset.

## Timing
- Reset values:
  - wr_valid=0, wr_addr=0, wr_rgb=0, busy=0, done=0, overrun=0.
  - prev_valid=0, state IDLE.
- Reset asserted mid-sequence: wr_valid drops asynchronously. The partial square stays in the buffer, and the next sequence skips ERASE.
- frame_tick sampled at edge 0:
  - busy=1 and wr_valid=1 with the first pixel from edge 1, if that pixel is unclipped.
  - Outputs are registered, so there is no combinational path from wr_ready to wr_valid.
- With wr_ready held high and no clipping:
  - One pixel per cycle.
  - ERASE and DRAW each take (size+1)^2 cycles.
  - The ERASE-to-DRAW transition adds no bubble.
- FINISH takes one cycle after the last DRAW transfer. done=1 in that cycle and busy falls with done.
- The earliest accepted next frame_tick is the cycle after done.

## Structure
- Package fb_pkg holds:
  - H_RES, V_RES, ADDR_W;
  - the rgb_t typedef (24-bit packed r/g/b);
  - the sequencer state enum.
- Sub-module rect_walker:
  - Given x0, y0, size, start and advance, it produces col, row, in_bounds and last.
  - A single instance is reused by ERASE and DRAW, reloaded at each phase start.
- The address multiply-free adder lives in the top level.

## Test plan
- First frame after reset, ball (10,20), size 3, wr_ready=1 → exactly 16 DRAW writes, no ERASE.
  - Addresses 6410..6413, 6730..6733, 7050..7053, 7370..7373 with ball_rgb.
  - done occurs 17 cycles after the tick.
- Second tick with the ball at (11,20), size 3 → 16 bg writes at the old addresses, then 16 ball writes starting at 6411. prev_* updates at done.
- Backpressure: wr_ready toggles 1,0,0,1,… → no transfer is lost or duplicated, and wr_addr/wr_rgb are stable while stalled. The write count is still 32.
- Clipping, ball (318,238), size 3 → only 4 writes in DRAW: cols 318-319 on rows 238-239. 12 skipped cycles with wr_valid low; done still arrives after 16 scan cycles.
- frame_tick during DRAW → overrun=1, the sequence completes unchanged, and no second sequence starts. overrun remains set until reset.
- Reset pulse in the middle of ERASE → all outputs go to 0 immediately. The next tick performs DRAW only, with no ERASE.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry, pixel colour type and sequencer state encoding
package fb_pkg;
   localparam int H_RES  = 320;
   localparam int V_RES  = 240;
   localparam int ADDR_W = 17;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;
   typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} seq_state_t;
   function automatic logic in_fb(input logic [11:0] c, input logic [11:0] r);
      return c < 12'(H_RES) && r < 12'(V_RES);
   endfunction
endpackage

// File: rtl/ball_draw_sequencer_if.sv
// ball_draw_sequencer_if: pixel write port from the sequencer to the frame-buffer arbiter
interface ball_draw_sequencer_if;
   import fb_pkg::*;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   rgb_t              wr_rgb;
   modport master (output wr_valid, wr_addr, wr_rgb, input wr_ready);
   modport slave  (input wr_valid, wr_addr, wr_rgb, output wr_ready);
endinterface

// File: rtl/rect_walker.sv
// rect_walker: row-major scan of a (size+1)^2 square starting at (x0,y0).
// col/row/in_bounds describe the pixel held after the coming edge; last describes the pixel held now.
module rect_walker
   import fb_pkg::*;
(
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [10:0] x0,
   input  logic [10:0] y0,
   input  logic [6:0]  size,
   input  logic        start,
   input  logic        advance,
   output logic [11:0] col,
   output logic [11:0] row,
   output logic        in_bounds,
   output logic        last
);
   logic [11:0] c, r, xs, xe, ye;
   assign col       = start ? {1'b0, x0} : !advance ? c : c == xe ? xs : c + 12'd1;
   assign row       = start ? {1'b0, y0} : (advance && c == xe) ? r + 12'd1 : r;
   assign in_bounds = in_fb(col, row);
   assign last      = c == xe && r == ye;
   always_ff @(posedge CLOCK_50 or negedge reset)
      if (!reset) begin
         c  <= '0;
         r  <= '0;
         xs <= '0;
         xe <= '0;
         ye <= '0;
      end else begin
         c <= col;
         r <= row;
         if (start) begin
            xs <= {1'b0, x0};
            xe <= {1'b0, x0} + 12'(size);
            ye <= {1'b0, y0} + 12'(size);
         end
      end
endmodule

// File: rtl/ball_draw_sequencer.sv
// ball_draw_sequencer: per-frame erase of the previous ball square and paint of the new one,
// one pixel per accepted write into the frame-buffer arbiter.
module ball_draw_sequencer
   import fb_pkg::*;
(
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [10:0] ball_x,
   input  logic [10:0] ball_y,
   input  logic [6:0]  size,
   input  rgb_t        ball_rgb,
   input  rgb_t        bg_rgb,
   ball_draw_sequencer_if.master wr,
   output logic        busy,
   output logic        done,
   output logic        overrun
);
   seq_state_t  state, nxt_state;
   logic [10:0] new_x, new_y, prev_x, prev_y, wk_x, wk_y;
   logic [6:0]  new_size, prev_size, wk_size;
   rgb_t        new_ball, new_bg, paint_ball, paint_bg;
   logic        prev_valid, active, adv, phase_end, tick_go, start;
   logic [11:0] col, row;
   logic        in_bounds, last;

   function automatic logic [ADDR_W-1:0] pix_addr(input logic [11:0] c, input logic [11:0] r);
      logic [19:0] a;
      a = {r, 8'd0} + 20'({r, 6'd0}) + 20'(c);
      return a[ADDR_W-1:0];
   endfunction

   // wr_valid low in a scanning state means the held pixel is clipped, so the scan moves on
   assign active     = state == ERASE || state == DRAW;
   assign adv        = active && (wr.wr_ready || !wr.wr_valid);
   assign phase_end  = adv && last;
   assign tick_go    = state == IDLE && frame_tick;
   assign start      = tick_go || (state == ERASE && phase_end);
   assign wk_x       = state != IDLE ? new_x : prev_valid ? prev_x : ball_x;
   assign wk_y       = state != IDLE ? new_y : prev_valid ? prev_y : ball_y;
   assign wk_size    = state != IDLE ? new_size : prev_valid ? prev_size : size;
   assign paint_ball = state == IDLE ? ball_rgb : new_ball;
   assign paint_bg   = state == IDLE ? bg_rgb : new_bg;

   always_comb
      nxt_state = state == IDLE  ? (frame_tick ? (prev_valid ? ERASE : DRAW) : IDLE) :
                  state == ERASE ? (phase_end ? DRAW : ERASE) :
                  state == DRAW  ? (phase_end ? FINISH : DRAW) : IDLE;

   rect_walker u_walker (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .x0       (wk_x),
      .y0       (wk_y),
      .size     (wk_size),
      .start    (start),
      .advance  (adv),
      .col      (col),
      .row      (row),
      .in_bounds(in_bounds),
      .last     (last)
   );

   always_ff @(posedge CLOCK_50 or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         wr.wr_valid <= 1'b0;
         wr.wr_addr  <= '0;
         wr.wr_rgb   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
         prev_valid  <= 1'b0;
         new_x       <= '0;
         new_y       <= '0;
         new_size    <= '0;
         new_ball    <= '0;
         new_bg      <= '0;
         prev_x      <= '0;
         prev_y      <= '0;
         prev_size   <= '0;
      end else begin
         state       <= nxt_state;
         wr.wr_valid <= (nxt_state == ERASE || nxt_state == DRAW) && in_bounds;
         wr.wr_addr  <= pix_addr(col, row);
         wr.wr_rgb   <= nxt_state == ERASE ? paint_bg : nxt_state == DRAW ? paint_ball : '0;
         busy        <= nxt_state != IDLE;
         done        <= nxt_state == FINISH;
         if (frame_tick && state != IDLE)
            overrun <= 1'b1;
         if (tick_go) begin
            new_x    <= ball_x;
            new_y    <= ball_y;
            new_size <= size;
            new_ball <= ball_rgb;
            new_bg   <= bg_rgb;
         end
         if (state == FINISH) begin
            prev_x     <= new_x;
            prev_y     <= new_y;
            prev_size  <= new_size;
            prev_valid <= 1'b1;
         end
      end
endmodule

// File: tb/tb_ball_draw_sequencer.sv
// tb_ball_draw_sequencer: directed frames against a write-log scoreboard
module tb_ball_draw_sequencer;
   import fb_pkg::*;
   logic        CLOCK_50 = 0;
   logic        reset, frame_tick;
   logic [10:0] ball_x, ball_y;
   logic [6:0]  size;
   logic [23:0] ball_rgb, bg_rgb;
   logic        busy, done, overrun;
   int          total = 0, passed = 0;
   int          skip_n = 0, stall_n = 0, stall_err = 0, pat = 0, cyc;
   logic        rdy_mode = 0, stalled = 0, b1;
   logic [40:0] held, log_q[$], exp_q[$];

   ball_draw_sequencer_if bus();

   ball_draw_sequencer dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .frame_tick(frame_tick),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .size      (size),
      .ball_rgb  (ball_rgb),
      .bg_rgb    (bg_rgb),
      .wr        (bus),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      #1 bus.wr_ready = rdy_mode ? (pat == 0) : 1'b1;
      pat = (pat + 1) % 3;
   end

   always @(negedge CLOCK_50) begin
      if (bus.wr_valid && bus.wr_ready) log_q.push_back({bus.wr_addr, bus.wr_rgb});
      if (stalled) begin
         stall_n++;
         if (!(bus.wr_valid && {bus.wr_addr, bus.wr_rgb} == held)) stall_err++;
      end
      stalled = bus.wr_valid && !bus.wr_ready;
      held    = {bus.wr_addr, bus.wr_rgb};
      if (busy && !bus.wr_valid && !done) skip_n++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
   endtask

   task automatic push_sq(input int x, input int y, input int s, input logic [23:0] rgb);
      for (int r = y; r <= y + s; r++)
         for (int c = x; c <= x + s; c++)
            if (c < 320 && r < 240) exp_q.push_back({17'(r * 320 + c), rgb});
   endtask

   task automatic cmp_log(input string tag);
      chk({tag, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk({tag, "_write"}, 64'(log_q[i]), 64'(exp_q[i]));
      exp_q.delete();
   endtask

   task automatic run_frame(input logic [10:0] x, input logic [10:0] y, input logic [6:0] s,
                            input logic [23:0] b, input logic [23:0] g, input int extra,
                            output int n, output logic bz);
      log_q.delete();
      skip_n = 0;
      ball_x = x; ball_y = y; size = s; ball_rgb = b; bg_rgb = g;
      frame_tick = 1;
      bz = 0;
      for (n = 1; n < 200; n++) begin
         @(posedge CLOCK_50);
         #1 frame_tick = (n == extra);
         if (n == extra) begin
            ball_x = 11'd999;
            ball_y = 11'd999;
         end
         @(negedge CLOCK_50);
         if (n == 1) bz = busy;
         if (done) break;
      end
      chk("done_seen", 64'(done), 1);
      @(posedge CLOCK_50);
      #1;
   endtask

   initial begin
      reset = 1; frame_tick = 0; ball_x = 0; ball_y = 0; size = 0; ball_rgb = 0; bg_rgb = 0;
      #3 reset = 0;
      #1;
      chk("rst_valid", 64'(bus.wr_valid), 0);
      chk("rst_addr", 64'(bus.wr_addr), 0);
      chk("rst_rgb", 64'(bus.wr_rgb), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_overrun", 64'(overrun), 0);
      repeat (3) @(posedge CLOCK_50);
      #1 reset = 1;
      @(posedge CLOCK_50);
      #1;
      // first frame: draw only
      push_sq(10, 20, 3, 24'hFF8000);
      run_frame(10, 20, 3, 24'hFF8000, 24'h102030, -1, cyc, b1);
      cmp_log("f1");
      chk("f1_cycles", 64'(cyc), 17);
      chk("f1_busy", 64'(b1), 1);
      chk("f1_skips", 64'(skip_n), 0);
      chk("f1_first_addr", 64'(log_q[0][40:24]), 6410);
      // second frame: erase old square then draw one column right
      push_sq(10, 20, 3, 24'h000011);
      push_sq(11, 20, 3, 24'h00FF00);
      run_frame(11, 20, 3, 24'h00FF00, 24'h000011, -1, cyc, b1);
      chk("f2_draw_addr", 64'(log_q[16][40:24]), 6411);
      cmp_log("f2");
      chk("f2_cycles", 64'(cyc), 33);
      // backpressure
      rdy_mode = 1; stall_n = 0; stall_err = 0;
      push_sq(11, 20, 3, 24'h0A0B0C);
      push_sq(12, 21, 3, 24'h123456);
      run_frame(12, 21, 3, 24'h123456, 24'h0A0B0C, -1, cyc, b1);
      rdy_mode = 0;
      cmp_log("f3");
      chk("f3_stall_stable", 64'(stall_err), 0);
      chk("f3_stalled", 64'(stall_n > 0), 1);
      // clipping at the bottom-right corner
      push_sq(12, 21, 3, 24'h555555);
      push_sq(318, 238, 3, 24'hABCDEF);
      run_frame(318, 238, 3, 24'hABCDEF, 24'h555555, -1, cyc, b1);
      cmp_log("f4");
      chk("f4_cycles", 64'(cyc), 33);
      chk("f4_skips", 64'(skip_n), 12);
      chk("f4_overrun", 64'(overrun), 0);
      // stray tick during DRAW
      push_sq(318, 238, 3, 24'h202020);
      push_sq(50, 60, 2, 24'hC0FFEE);
      run_frame(50, 60, 2, 24'hC0FFEE, 24'h202020, 20, cyc, b1);
      cmp_log("f5");
      chk("f5_cycles", 64'(cyc), 26);
      chk("f5_skips", 64'(skip_n), 12);
      chk("f5_overrun", 64'(overrun), 1);
      repeat (6) @(posedge CLOCK_50);
      #1;
      chk("f5_no_restart", 64'(busy), 0);
      chk("f5_log_static", 64'(log_q.size()), 13);
      chk("f5_overrun_sticky", 64'(overrun), 1);
      // reset in the middle of ERASE
      ball_x = 70; ball_y = 80; size = 1; ball_rgb = 24'h777777; bg_rgb = 24'h010101;
      frame_tick = 1;
      @(posedge CLOCK_50);
      #1 frame_tick = 0;
      repeat (3) @(posedge CLOCK_50);
      #1;
      chk("mid_busy", 64'(busy), 1);
      chk("mid_valid", 64'(bus.wr_valid), 1);
      #2 reset = 0;
      #1;
      chk("mid_rst_valid", 64'(bus.wr_valid), 0);
      chk("mid_rst_addr", 64'(bus.wr_addr), 0);
      chk("mid_rst_rgb", 64'(bus.wr_rgb), 0);
      chk("mid_rst_busy", 64'(busy), 0);
      chk("mid_rst_overrun", 64'(overrun), 0);
      @(posedge CLOCK_50);
      #1 reset = 1;
      @(posedge CLOCK_50);
      #1;
      push_sq(70, 80, 1, 24'h777777);
      run_frame(70, 80, 1, 24'h777777, 24'h010101, -1, cyc, b1);
      cmp_log("f6");
      chk("f6_cycles", 64'(cyc), 5);
      chk("f6_skips", 64'(skip_n), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
